// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-drain UART transmitter: FSM encoding and line levels.
package fifo_uart_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // bit_end is not masked by clear: a pop on the last stop cycle still needs the tick.
  assign bit_end = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_cnt <= '0;
    else if (clear || bit_end) r_cnt <= '0;
    else                       r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO one word at a time onto a start/data(LSB first)/stop serial line.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_en,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_rdata,
  output logic               fifo_ren,
  output logic               tx,
  output logic               busy,
  output logic               tx_done
);
  localparam int IW = $clog2(D_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(D_WIDTH - 1);

  logic [1:0]         r_state;
  logic [D_WIDTH-1:0] r_shift;
  logic [IW-1:0]      r_idx;
  logic               r_tx;
  logic               w_bit_end;
  logic               w_pop;
  logic [D_WIDTH-1:0] w_shift_nxt;

  // Gated by rst so the pop strobe drops the instant reset is asserted.
  assign w_pop = ~rst & tx_en & ~fifo_empty &
                 ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
  assign w_shift_nxt = r_shift >> 1;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_pop),
    .bit_end(w_bit_end)
  );

  // tx is registered alongside the state so each level lands with its state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= LINE_IDLE;
    end else if (w_pop) begin
      r_shift <= fifo_rdata;
      r_state <= START;
      r_tx    <= START_BIT;
    end else if (w_bit_end) begin
      case (r_state)
        START: begin
          r_state <= DATA;
          r_idx   <= '0;
          r_tx    <= r_shift[0];
        end
        DATA: begin
          r_shift <= w_shift_nxt;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= STOP;
            r_tx    <= LINE_IDLE;
          end else begin
            r_tx    <= w_shift_nxt[0];
          end
        end
        STOP: begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_ren = w_pop;
  assign tx       = r_tx;
  assign busy     = (r_state != IDLE);
  assign tx_done  = (r_state == STOP) & w_bit_end;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a queue-based show-ahead FIFO model.
module tb_fifo_uart_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int TN  = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_ren, tx, busy, tx_done;

  int n_cmp = 0;
  int n_err = 0;
  int bad_ren = 0;
  int tn = 0;

  logic [DW-1:0] fq[$];
  logic t_tx[TN], t_ren[TN], t_done[TN], t_busy[TN];

  always #5 clk = ~clk;

  fifo_uart_tx #(.D_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_ren  (fifo_ren),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fq[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // Samples one cycle mid-period, then advances past the next edge and retires a pop.
  task automatic cyc();
    logic p;
    #1;
    p = fifo_ren;
    if (fifo_ren && fifo_empty) bad_ren++;
    if (tn < TN) begin
      t_tx[tn] = tx; t_ren[tn] = fifo_ren; t_done[tn] = tx_done; t_busy[tn] = busy;
    end
    tn++;
    @(posedge clk);
    #1;
    if (p) fq.delete(0);
    refresh();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  function automatic int cnt_ren(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (t_ren[i]) c++;
    return c;
  endfunction

  function automatic int cnt_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (t_done[i]) c++;
    return c;
  endfunction

  function automatic int cnt_busy(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (t_busy[i]) c++;
    return c;
  endfunction

  function automatic int cnt_txhi(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (t_tx[i]) c++;
    return c;
  endfunction

  function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k == DW + 1) return 1'b1;
    return w[k-1];
  endfunction

  task automatic chk_frame(input string tag, input logic [DW-1:0] w, input int off);
    logic [CPB-1:0] v;
    for (int k = 0; k < DW + 2; k++) begin
      for (int j = 0; j < CPB; j++) v[j] = t_tx[off + k*CPB + j];
      chk($sformatf("%s_bit%0d", tag, k), 32'(v), 32'({CPB{exp_bit(w, k)}}));
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ren", 32'(fifo_ren), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // empty FIFO, enabled: nothing happens
    tx_en = 1'b1;
    tn = 0; run(100);
    chk("empty_ren", 32'(cnt_ren(0, 99)), 32'd0);
    chk("empty_txhi", 32'(cnt_txhi(0, 99)), 32'd100);
    chk("empty_busy", 32'(cnt_busy(0, 99)), 32'd0);

    // data present, disabled: no pop
    tx_en = 1'b0;
    push(8'hA5);
    tn = 0; run(20);
    chk("dis_ren", 32'(cnt_ren(0, 19)), 32'd0);
    chk("dis_busy", 32'(cnt_busy(0, 19)), 32'd0);
    chk("dis_qsize", 32'(fq.size()), 32'd1);

    // single word 0xA5
    tx_en = 1'b1;
    tn = 0; run(44);
    chk("one_ren0", 32'(t_ren[0]), 32'd1);
    chk("one_nren", 32'(cnt_ren(0, 43)), 32'd1);
    chk_frame("one", 8'hA5, 1);
    chk("one_done40", 32'(t_done[40]), 32'd1);
    chk("one_ndone", 32'(cnt_done(0, 43)), 32'd1);
    chk("one_busy40", 32'(t_busy[40]), 32'd1);
    chk("one_busy41", 32'(t_busy[41]), 32'd0);
    chk("one_tx41", 32'(t_tx[41]), 32'd1);

    // back-to-back 0x00 then 0xFF
    push(8'h00); push(8'hFF);
    tn = 0; run(85);
    chk("b2b_ren0", 32'(t_ren[0]), 32'd1);
    chk("b2b_ren40", 32'(t_ren[40]), 32'd1);
    chk("b2b_nren", 32'(cnt_ren(0, 84)), 32'd2);
    chk("b2b_done40", 32'(t_done[40]), 32'd1);
    chk("b2b_done80", 32'(t_done[80]), 32'd1);
    chk("b2b_ndone", 32'(cnt_done(0, 84)), 32'd2);
    chk_frame("b2b0", 8'h00, 1);
    chk_frame("b2b1", 8'hFF, 41);
    chk("b2b_busy", 32'(cnt_busy(1, 80)), 32'd80);
    chk("b2b_busy81", 32'(t_busy[81]), 32'd0);

    // tx_en dropped mid-frame with three words queued
    push(8'h11); push(8'h22); push(8'h33);
    tn = 0; run(12);
    tx_en = 1'b0;
    run(40);
    chk("drop_nren", 32'(cnt_ren(0, 51)), 32'd1);
    chk_frame("drop", 8'h11, 1);
    chk("drop_done40", 32'(t_done[40]), 32'd1);
    chk("drop_busy41", 32'(t_busy[41]), 32'd0);
    chk("drop_qsize", 32'(fq.size()), 32'd2);
    tn = 0; run(10);
    chk("drop_idle_ren", 32'(cnt_ren(0, 9)), 32'd0);
    tx_en = 1'b1;
    tn = 0; run(41);
    chk("resume_ren0", 32'(t_ren[0]), 32'd1);
    chk_frame("resume", 8'h22, 1);
    chk("resume_ren40", 32'(t_ren[40]), 32'd1);
    chk("resume_done40", 32'(t_done[40]), 32'd1);
    tn = 0; run(42);
    chk_frame("w3", 8'h33, 0);
    chk("w3_done39", 32'(t_done[39]), 32'd1);
    chk("w3_busy40", 32'(t_busy[40]), 32'd0);
    chk("w3_nren", 32'(cnt_ren(0, 41)), 32'd0);

    // reset during data bit 3 of 0x52 (bit 3 = 0)
    push(8'h52); push(8'h6B);
    tn = 0; run(18);
    chk("mid_d3", 32'(t_tx[17]), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ren", 32'(fifo_ren), 32'd0);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    cyc();
    rst = 1'b0;
    tn = 0; run(48);
    chk("after_ren0", 32'(t_ren[0]), 32'd1);
    chk_frame("after", 8'h6B, 1);
    chk("after_done40", 32'(t_done[40]), 32'd1);
    chk("after_nren", 32'(cnt_ren(0, 47)), 32'd1);
    chk("after_busy41", 32'(t_busy[41]), 32'd0);
    chk("after_qsize", 32'(fq.size()), 32'd0);
    chk("ren_while_empty", 32'(bad_ren), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the synchronous FIFO: pops one word at a time from the FIFO read port and transmits it on a single serial line as an 8N1-style UART frame. The frame is one start bit, D_WIDTH data bits LSB first, and one stop bit. The block sits directly on the FIFO's empty / read-enable / read-data port and is the FIFO's only consumer. Frames are sent back-to-back with no idle gap while the FIFO holds data and transmission is enabled.

## Interface
Parameters:
- D_WIDTH, 8, data word width; must match the FIFO's d_width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_en  in  1  when high, the block may start new frames.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  D_WIDTH  FIFO head word; show-ahead, valid whenever fifo_empty=0.
- fifo_ren  out  1  pop strobe to the FIFO; combinational.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in progress.
- tx_done  out  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- The only clock is clk. Reset is asynchronous and active-high on rst.
- FSM states are IDLE, START, DATA and STOP.
- Reset values:
  - state = IDLE
  - tx = 1, busy = 0, tx_done = 0, fifo_ren = 0
  - baud counter = 0, bit index = 0, shift register = 0
- Pop condition is pop = tx_en & ~fifo_empty & (state==IDLE | last cycle of STOP). fifo_ren = pop.
- On a pop edge:
  - shift register <= fifo_rdata
  - baud counter <= 0
  - state <= START
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
- DATA: tx = shift register[0] for each bit period.
  - At the end of each bit: shift right by one and increment the bit index.
  - After bit D_WIDTH-1, go to STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles.
  - The last cycle asserts tx_done.
  - Next state is START if pop, otherwise IDLE.
- busy = (state != IDLE).
- tx is registered from state and the shift register, so there are no glitches.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0 to CLKS_PER_BIT-1, then wraps to 0 and issues a bit_end tick.
- Bit index: width $clog2(D_WIDTH)+1. It never wraps inside a frame.
- Boundary conditions:
  - fifo_empty=1 in IDLE: no pop and no state change.
  - tx_en dropped mid-frame: the current frame completes; no further pop.
  - fifo_empty rising mid-frame: no effect until the next pop decision.
  - rst mid-frame: the frame is aborted immediately and tx returns high. The popped word is lost; there is no retry.
  - fifo_ren is never asserted while fifo_empty=1.

## Timing
- Pop to start bit: the start bit appears on tx in the cycle after the fifo_ren edge.
- Frame length is exactly (D_WIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the previous stop bit's last cycle. There is zero gap.
- tx_done coincides with the fifo_ren of the next word when a back-to-back frame follows.
- Throughput is one word per (D_WIDTH+2)*CLKS_PER_BIT cycles.
- Latency from a FIFO write to the start bit is at least 2 cycles: FIFO empty deasserts, then the pop cycle, then the start bit.

## Structure
- Shared package fifo_uart_pkg holds:
  - the state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3)
  - the line constants LINE_IDLE=1'b1 and START_BIT=1'b0
- Sub-module baud_tick_gen, parameter CLKS_PER_BIT.
  - Input clear: restarts the count.
  - Output bit_end: one-cycle tick when the count wraps.
  - The FSM drives clear on pop.
- FSM, shift register and bit index live in fifo_uart_tx.

## Test plan
- Reset: assert rst mid-run -> tx=1, busy=0, fifo_ren=0, tx_done=0 immediately and asynchronously.
- Single word, CLKS_PER_BIT=4, push 0xA5, tx_en=1 -> exactly one fifo_ren pulse. tx then holds each level for 4 cycles in this order: 0, 1,0,1,0,0,1,0,1, then 1 (start, LSB-first data, stop). tx_done fires at cycle 40 of the frame, and busy is low after it.
- Back-to-back: push 0x00 then 0xFF -> two frames with no idle cycle between them. The second fifo_ren lands in the same cycle as the first tx_done, and the total is 80 cycles.
- Empty / disabled:
  - FIFO empty with tx_en=1 for 100 cycles -> no fifo_ren, tx=1.
  - Data present with tx_en=0 -> no pop.
- tx_en drop: deassert tx_en during the DATA bits of frame 1 while 3 words are queued -> frame 1 completes intact and no second pop occurs. Reasserting tx_en resumes with word 2.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 at once. After release, the next frame starts with the next queued word, and no fifo_ren fires while fifo_empty=1.
